// File: rtl/axi_lite_wr_ctrl_if.sv
// AXI4-Lite write-channel bundle (AW, W and B) shared between an
// interconnect master and the axi_lite_wr_ctrl slave.
//
// Parameters:
//   ADDR_W  AXI byte-address width
//   DATA_W  data width (wstrb is DATA_W/8 bits)
//
// Signals:
//   awaddr/awvalid/awready   write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bresp/bvalid/bready       write response channel
//
// Modports:
//   master  drives addresses, data and bready
//   slave   drives the readies and the B response
interface axi_lite_wr_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_wr_ctrl.sv
// AXI4-Lite slave write-channel sequencer for the core register file.
// Accepts the AW and W beats in either order (or together), then issues a
// single-cycle register write strobe and returns a B response that is held
// until the master takes it. The read channel is not handled here.
//
// Parameters:
//   ADDR_W    AXI byte-address width; word index is awaddr[ADDR_W-1:2]
//   DATA_W    data width (32)
//   NUM_REGS  number of implemented registers (address check only)
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   bus        AXI-Lite write channels (slave modport)
//   reg_we     one-cycle register write strobe
//   reg_addr   captured word index
//   reg_wdata  captured write data
//   reg_wstrb  captured byte strobes (passed through unmodified)
//   fsm_state  current state for debug/observation
//   busy       high whenever the sequencer is not idle
//
// Configuration:
//   AXIL_WR_ADDR_CHECK_EN  when defined, a word index >= NUM_REGS returns
//                          SLVERR and suppresses reg_we; otherwise every
//                          transaction answers OKAY and pulses reg_we.
module axi_lite_wr_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst,
  axi_lite_wr_ctrl_if.slave   bus,
  output logic                reg_we,
  output logic [ADDR_W-3:0]   reg_addr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [DATA_W/8-1:0] reg_wstrb,
  output logic [1:0]          fsm_state,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DONE         = 2'd1,
    WAITING_DATA = 2'd2,
    WAITING_ADDR = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t            state;
  logic [1:0]        bresp_q;
  logic [ADDR_W-3:0] aw_idx;
  logic              aw_hs;
  logic              w_hs;
  logic              new_ok;
  logic              held_ok;
  logic              unused_addr_bits;

  // Byte offset within a word carries no meaning for word registers.
  assign aw_idx           = bus.awaddr[ADDR_W-1:2];
  assign unused_addr_bits = &{1'b0, bus.awaddr[1:0]};

  // Readies and bvalid are pure decodes of the registered state, so they
  // never depend combinationally on the master's valids.
  assign bus.awready = (state == IDLE) || (state == WAITING_ADDR);
  assign bus.wready  = (state == IDLE) || (state == WAITING_DATA);
  assign bus.bvalid  = (state == DONE);
  assign bus.bresp   = bresp_q;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;

  assign fsm_state = state;
  assign busy      = (state != IDLE);

  // new_ok judges an address arriving this cycle; held_ok judges the index
  // already captured while waiting for the data beat.
`ifdef AXIL_WR_ADDR_CHECK_EN
  localparam int unsigned NUM_REGS_U = NUM_REGS;
  assign new_ok  = (32'(aw_idx) < NUM_REGS_U);
  assign held_ok = (32'(reg_addr) < NUM_REGS_U);
`else
  localparam int unused_num_regs = NUM_REGS;
  assign new_ok  = 1'b1;
  assign held_ok = 1'b1;
`endif

  // Sequencer. Whichever beat completes the pair moves to DONE and fires
  // reg_we in the same edge, so the strobe lines up with the first DONE
  // cycle. reg_we defaults low every cycle, which makes it a single pulse
  // no matter how long the master stalls bready. bresp is cleared once the
  // response is taken so a stale SLVERR never lingers on an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bresp_q   <= RESP_OKAY;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      reg_we <= 1'b0;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            reg_addr <= aw_idx;
          end
          if (w_hs) begin
            reg_wdata <= bus.wdata;
            reg_wstrb <= bus.wstrb;
          end
          if (aw_hs && w_hs) begin
            state   <= DONE;
            reg_we  <= new_ok;
            bresp_q <= new_ok ? RESP_OKAY : RESP_SLVERR;
          end else if (aw_hs) begin
            state <= WAITING_DATA;
          end else if (w_hs) begin
            state <= WAITING_ADDR;
          end
        end
        WAITING_DATA: begin
          if (w_hs) begin
            reg_wdata <= bus.wdata;
            reg_wstrb <= bus.wstrb;
            state     <= DONE;
            reg_we    <= held_ok;
            bresp_q   <= held_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        WAITING_ADDR: begin
          if (aw_hs) begin
            reg_addr <= aw_idx;
            state    <= DONE;
            reg_we   <= new_ok;
            bresp_q  <= new_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        DONE: begin
          if (bus.bready) begin
            state   <= IDLE;
            bresp_q <= RESP_OKAY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_wr_ctrl.sv
// Testbench for axi_lite_wr_ctrl: a table of directed vectors, hand-written
// reset and address-check sequences, and a randomized run compared against
// a transaction-level reference model.
module tb_axi_lite_wr_ctrl;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

`ifdef AXIL_WR_ADDR_CHECK_EN
  localparam logic       T6_WE    = 1'b0;
  localparam logic [1:0] T6_BRESP = 2'b10;
`else
  localparam logic       T6_WE    = 1'b1;
  localparam logic [1:0] T6_BRESP = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_we;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [1:0]  fsm_state;
  logic        busy;

  axi_lite_wr_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_lite_wr_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wstrb (reg_wstrb),
    .fsm_state (fsm_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        reg_we;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic [1:0]  fsm_state;
    logic        busy;
  } exp_t;

  typedef struct packed {
    logic        awvalid;
    logic [7:0]  awaddr;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;
    exp_t        exp;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // Transaction-level reference model: which beats are held, whether a
  // response is owed, and the last captured register fields.
  logic        m_have_addr, m_have_data, m_pend, m_we;
  logic [1:0]  m_bresp;
  logic [5:0]  m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_strb;

  function automatic exp_t mk(input logic awr, input logic wr, input logic bv,
                              input logic [1:0] br, input logic we,
                              input logic [5:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] st);
    exp_t e;
    e.awready = awr;  e.wready = wr;  e.bvalid = bv;  e.bresp = br;
    e.reg_we = we;    e.reg_addr = a; e.reg_wdata = d; e.reg_wstrb = s;
    e.fsm_state = st; e.busy = (st != 2'd0);
    return e;
  endfunction

  function automatic vec_t mkv(input logic av, input logic [7:0] aa, input logic wv,
                               input logic [31:0] wd, input logic [3:0] ws,
                               input logic br, input exp_t e);
    vec_t v;
    v.awvalid = av; v.awaddr = aa; v.wvalid = wv; v.wdata = wd;
    v.wstrb = ws;   v.bready = br; v.exp = e;
    return v;
  endfunction

  task automatic modelReset();
    m_have_addr = 1'b0; m_have_data = 1'b0; m_pend = 1'b0; m_we = 1'b0;
    m_bresp = 2'b00; m_addr = '0; m_data = '0; m_strb = '0;
  endtask

  function automatic exp_t modelExp();
    logic [1:0] st;
    if (m_pend)           st = 2'd1;
    else if (m_have_addr) st = 2'd2;
    else if (m_have_data) st = 2'd3;
    else                  st = 2'd0;
    return mk(!m_have_addr && !m_pend, !m_have_data && !m_pend, m_pend, m_bresp,
              m_we, m_addr, m_data, m_strb, st);
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s got=%h expected=%h", name, got, want);
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    cmp({tag, ".awready"},   32'(bus.awready), 32'(e.awready));
    cmp({tag, ".wready"},    32'(bus.wready),  32'(e.wready));
    cmp({tag, ".bvalid"},    32'(bus.bvalid),  32'(e.bvalid));
    if (e.bvalid) cmp({tag, ".bresp"}, 32'(bus.bresp), 32'(e.bresp));
    cmp({tag, ".reg_we"},    32'(reg_we),      32'(e.reg_we));
    cmp({tag, ".reg_addr"},  32'(reg_addr),    32'(e.reg_addr));
    cmp({tag, ".reg_wdata"}, reg_wdata,        e.reg_wdata);
    cmp({tag, ".reg_wstrb"}, 32'(reg_wstrb),   32'(e.reg_wstrb));
    cmp({tag, ".fsm_state"}, 32'(fsm_state),   32'(e.fsm_state));
    cmp({tag, ".busy"},      32'(busy),        32'(e.busy));
  endtask

  // Drive one cycle of inputs, clock it, advance the model, and return
  // #1 after the edge so outputs can be sampled.
  task automatic applyStimulus(input logic av, input logic [7:0] aa, input logic wv,
                               input logic [31:0] wd, input logic [3:0] ws,
                               input logic br);
    exp_t e;
    logic aw_hs, w_hs, b_hs, ok;
    e = modelExp();
    bus.awvalid = av; bus.awaddr = aa; bus.wvalid = wv;
    bus.wdata = wd;   bus.wstrb = ws;  bus.bready = br;
    aw_hs = av && e.awready;
    w_hs  = wv && e.wready;
    b_hs  = e.bvalid && br;
    @(posedge clk);
    m_we = 1'b0;
    if (b_hs) begin
      m_pend  = 1'b0;
      m_bresp = 2'b00;
    end
    if (aw_hs) begin
      m_addr = aa[7:2];
      m_have_addr = 1'b1;
    end
    if (w_hs) begin
      m_data = wd;
      m_strb = ws;
      m_have_data = 1'b1;
    end
    if (m_have_addr && m_have_data) begin
`ifdef AXIL_WR_ADDR_CHECK_EN
      ok = (int'(m_addr) < NUM_REGS);
`else
      ok = 1'b1;
`endif
      m_have_addr = 1'b0;
      m_have_data = 1'b0;
      m_pend  = 1'b1;
      m_we    = ok;
      m_bresp = ok ? 2'b00 : 2'b10;
    end
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    rst = 1'b1;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.bready = 1'b0;
    modelReset();

    // T1 simultaneous beats
    vecs[0]  = mkv(1, 8'h08, 1, 32'hDEADBEEF, 4'hF, 1, mk(0,0,1,2'b00,1,6'd2,32'hDEADBEEF,4'hF,2'd1));
    vecs[1]  = mkv(0, 8'h00, 0, 32'h0,        4'h0, 1, mk(1,1,0,2'b00,0,6'd2,32'hDEADBEEF,4'hF,2'd0));
    // T2 AW first, second AW ignored while waiting, W three cycles later
    vecs[2]  = mkv(1, 8'h04, 0, 32'h0,        4'h0, 1, mk(0,1,0,2'b00,0,6'd1,32'hDEADBEEF,4'hF,2'd2));
    vecs[3]  = mkv(1, 8'h3C, 0, 32'h0,        4'h0, 1, mk(0,1,0,2'b00,0,6'd1,32'hDEADBEEF,4'hF,2'd2));
    vecs[4]  = mkv(0, 8'h00, 0, 32'h0,        4'h0, 1, mk(0,1,0,2'b00,0,6'd1,32'hDEADBEEF,4'hF,2'd2));
    vecs[5]  = mkv(0, 8'h00, 1, 32'hCAFE0001, 4'h3, 0, mk(0,0,1,2'b00,1,6'd1,32'hCAFE0001,4'h3,2'd1));
    // T4 backpressure: bready low, new beats offered but refused
    for (int i = 6; i <= 9; i++)
      vecs[i] = mkv(1, 8'h20, 1, 32'h11111111, 4'hF, 0, mk(0,0,1,2'b00,0,6'd1,32'hCAFE0001,4'h3,2'd1));
    vecs[10] = mkv(0, 8'h00, 0, 32'h0,        4'h0, 1, mk(1,1,0,2'b00,0,6'd1,32'hCAFE0001,4'h3,2'd0));
    // T3 W first with all-zero strobes, AW two cycles later
    vecs[11] = mkv(0, 8'h00, 1, 32'h00001234, 4'h0, 1, mk(1,0,0,2'b00,0,6'd1,32'h00001234,4'h0,2'd3));
    vecs[12] = mkv(0, 8'h00, 1, 32'hFFFFFFFF, 4'hF, 1, mk(1,0,0,2'b00,0,6'd1,32'h00001234,4'h0,2'd3));
    vecs[13] = mkv(1, 8'h17, 0, 32'h0,        4'h0, 0, mk(0,0,1,2'b00,1,6'd5,32'h00001234,4'h0,2'd1));
    vecs[14] = mkv(0, 8'h00, 0, 32'h0,        4'h0, 1, mk(1,1,0,2'b00,0,6'd5,32'h00001234,4'h0,2'd0));
    // T6 first out-of-range index
    vecs[15] = mkv(1, 8'h40, 1, 32'hA5A5A5A5, 4'hF, 0, mk(0,0,1,T6_BRESP,T6_WE,6'd16,32'hA5A5A5A5,4'hF,2'd1));
    vecs[16] = mkv(0, 8'h00, 0, 32'h0,        4'h0, 1, mk(1,1,0,2'b00,0,6'd16,32'hA5A5A5A5,4'hF,2'd0));

    @(posedge clk);
    #1;
    checkOutput(mk(1,1,0,2'b00,0,6'd0,32'h0,4'h0,2'd0), "reset");
    cmp("reset.bresp", 32'(bus.bresp), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].awvalid, vecs[i].awaddr, vecs[i].wvalid,
                    vecs[i].wdata, vecs[i].wstrb, vecs[i].bready);
      checkOutput(vecs[i].exp, $sformatf("vec%0d", i));
    end

    // T5 reset while waiting for data: the captured address must be dropped
    applyStimulus(1, 8'h0C, 0, 32'h0, 4'h0, 1);
    checkOutput(mk(0,1,0,2'b00,0,6'd3,32'hA5A5A5A5,4'hF,2'd2), "t5_wait");
    rst = 1'b1;
    modelReset();
    #2;
    checkOutput(mk(1,1,0,2'b00,0,6'd0,32'h0,4'h0,2'd0), "t5_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 8'h00, 1, 32'h55AA55AA, 4'h6, 1);
    checkOutput(mk(1,0,0,2'b00,0,6'd0,32'h55AA55AA,4'h6,2'd3), "t5_w");
    applyStimulus(1, 8'h0C, 0, 32'h0, 4'h0, 1);
    checkOutput(mk(0,0,1,2'b00,1,6'd3,32'h55AA55AA,4'h6,2'd1), "t5_done");
    applyStimulus(0, 8'h00, 0, 32'h0, 4'h0, 1);
    checkOutput(mk(1,1,0,2'b00,0,6'd3,32'h55AA55AA,4'h6,2'd0), "t5_idle");

    // Randomized traffic against the reference model, with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      if (i == 200) begin
        rst = 1'b1;
        modelReset();
        #2;
        checkOutput(modelExp(), "rand_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
      applyStimulus(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
                    $urandom(), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 9) < 6));
      checkOutput(modelExp(), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
